// File: rtl/lc3b_data_mem_responder_pkg.sv
// rtl/lc3b_data_mem_responder_pkg.sv - shared LC-3b memory types, responder states and limits
// Optional feature macro used by this slice: LC3B_MEM_BOUNDS_CHECK_EN
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lc3b_mem_state;

  localparam int LC3B_MEM_MAX_LATENCY = 15;

endpackage

// File: rtl/lc3b_data_mem_responder_if.sv
// rtl/lc3b_data_mem_responder_if.sv - MEM-stage data port bundle with requester/responder modports
// mem_err exists only when LC3B_MEM_BOUNDS_CHECK_EN is defined
interface lc3b_data_mem_responder_if #(
  parameter int ADDR_WIDTH = 16
) ();
  import lc3b_types::*;

  logic                  mem_read;
  logic                  mem_write;
  lc3b_mem_wmask         mem_byte_enable;
  logic [ADDR_WIDTH-1:0] mem_address;
  lc3b_word              mem_wdata;
  logic                  mem_resp;
  lc3b_word              mem_rdata;
  logic                  busy;
`ifdef LC3B_MEM_BOUNDS_CHECK_EN
  logic                  mem_err;
`endif

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata, busy
`ifdef LC3B_MEM_BOUNDS_CHECK_EN
    , input mem_err
`endif
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata, busy
`ifdef LC3B_MEM_BOUNDS_CHECK_EN
    , output mem_err
`endif
  );

endinterface

// File: rtl/lc3b_data_mem_responder_mem_array.sv
// rtl/lc3b_data_mem_responder_mem_array.sv - single-port 16-bit word array with byte-write mask
// Contents are deliberately not reset; read data is registered and only changes on reads.
module lc3b_mem_array
  import lc3b_types::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  lc3b_mem_wmask i_wmask,
  input  logic [AW-1:0] i_addr,
  input  lc3b_word      i_wdata,
  output lc3b_word      o_rdata
);

  lc3b_word r_mem [DEPTH_WORDS];
  lc3b_word r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        if (i_wmask[0]) r_mem[i_addr][7:0]  <= i_wdata[7:0];
        if (i_wmask[1]) r_mem[i_addr][15:8] <= i_wdata[15:8];
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/lc3b_data_mem_responder.sv
// rtl/lc3b_data_mem_responder.sv - fixed-latency responder for the MEM-stage data port
// Define LC3B_MEM_BOUNDS_CHECK_EN for mem_err and out-of-range suppression instead of wrap-around.
module lc3b_data_mem_responder
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  lc3b_data_mem_responder_if.slave  bus
);

  localparam int         AW     = $clog2(DEPTH_WORDS);
  localparam int         IW     = ADDR_WIDTH - 1;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  generate
    if (LATENCY < 1 || LATENCY > LC3B_MEM_MAX_LATENCY) begin : g_bad_latency
      $error("lc3b_data_mem_responder: LATENCY must be in 1..15");
    end
  endgenerate

  lc3b_mem_state r_state, w_next;
  logic [3:0]    r_cnt, w_cnt;
  logic          r_op_write;
  logic [IW-1:0] r_idx;
  lc3b_word      r_wdata;
  lc3b_mem_wmask r_be;
  lc3b_word      r_rdata;

  logic          w_accept, w_req_write, w_commit, w_oob, w_rd_resp;
  logic [IW-1:0] w_idx;
  lc3b_word      w_wdata, w_arr_rdata, w_rdata_out;
  lc3b_mem_wmask w_be;

  // With LATENCY=1 the array is accessed on the accept edge itself, so use the live request.
  assign w_accept    = (r_state == IDLE) && (bus.mem_read || bus.mem_write);
  assign w_req_write = w_accept ? bus.mem_write : r_op_write;
  assign w_idx       = w_accept ? bus.mem_address[ADDR_WIDTH-1:1] : r_idx;
  assign w_wdata     = w_accept ? bus.mem_wdata : r_wdata;
  assign w_be        = w_accept ? bus.mem_byte_enable : r_be;
  assign w_commit    = (r_state != RESP) && (w_next == RESP);

`ifdef LC3B_MEM_BOUNDS_CHECK_EN
  logic r_err;
  assign w_oob       = (w_idx >= IW'(DEPTH_WORDS));
  assign w_rdata_out = r_err ? 16'h0000 : w_arr_rdata;
  assign bus.mem_err = r_err;
`else
  assign w_oob       = 1'b0;
  assign w_rdata_out = w_arr_rdata;
`endif

  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          w_cnt  = LAT_M1;
          w_next = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        w_cnt = r_cnt - 4'd1;
        if (w_cnt == 4'd0) w_next = RESP;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_op_write <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= 16'h0000;
      r_be       <= 2'b00;
      r_rdata    <= 16'h0000;
`ifdef LC3B_MEM_BOUNDS_CHECK_EN
      r_err      <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      if (w_accept) begin
        r_op_write <= bus.mem_write;
        r_idx      <= bus.mem_address[ADDR_WIDTH-1:1];
        r_wdata    <= bus.mem_wdata;
        r_be       <= bus.mem_byte_enable;
      end
      if (w_rd_resp) r_rdata <= w_rdata_out;
`ifdef LC3B_MEM_BOUNDS_CHECK_EN
      r_err <= w_commit && w_oob;
`endif
    end
  end

  lc3b_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .i_en    (w_commit && !w_oob),
    .i_we    (w_req_write),
    .i_wmask (w_be),
    .i_addr  (w_idx[AW-1:0]),
    .i_wdata (w_wdata),
    .o_rdata (w_arr_rdata)
  );

  // The array output register carries the read word during RESP; r_rdata holds it afterwards.
  assign w_rd_resp     = (r_state == RESP) && !r_op_write;
  assign bus.mem_rdata = w_rd_resp ? w_rdata_out : r_rdata;
  assign bus.mem_resp  = (r_state == RESP);
  assign bus.busy      = (r_state != IDLE);

  logic w_unused;
  assign w_unused = &{1'b0, bus.mem_address[0], w_idx[IW-1:AW]};

endmodule

// File: tb/tb_lc3b_data_mem_responder.sv
// tb/tb_lc3b_data_mem_responder.sv - directed self-checking bench for lc3b_data_mem_responder
// Bounds expectations follow LC3B_MEM_BOUNDS_CHECK_EN when it is defined.
module tb_lc3b_data_mem_responder;
  import lc3b_types::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   lat, bcnt, gap;
  logic err;

  lc3b_data_mem_responder_if #(.ADDR_WIDTH(16)) bus ();

  lc3b_data_mem_responder #(
    .ADDR_WIDTH  (16),
    .DEPTH_WORDS (1024),
    .LATENCY     (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge with the responder idle; returns at a negedge with it idle again.
  task automatic do_op(input logic rd, input logic wr, input logic [1:0] be,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       output int o_lat, output int o_busy, output logic o_err);
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_byte_enable = be;
    bus.mem_address     = addr;
    bus.mem_wdata       = wdata;
    o_lat  = 0;
    o_busy = 0;
    o_err  = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.busy) o_busy++;
      if (bus.mem_resp) begin
        o_lat = n;
`ifdef LC3B_MEM_BOUNDS_CHECK_EN
        o_err = bus.mem_err;
`endif
        break;
      end
    end
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    @(negedge clk);
    check("resp_single_cycle", {31'd0, bus.mem_resp}, 32'd0);
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_byte_enable = 2'b00;
    bus.mem_address     = 16'h0000;
    bus.mem_wdata       = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_resp", {31'd0, bus.mem_resp}, 32'd0);
    check("rst_rdata", {16'd0, bus.mem_rdata}, 32'h0000);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    dut.u_array.r_mem[10'h010] = 16'hBEEF;
    dut.u_array.r_mem[10'h040] = 16'h0001;
    dut.u_array.r_mem[10'h001] = 16'h1111;
    rst_n = 1'b1;
    @(negedge clk);

    do_op(1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000, lat, bcnt, err);
    check("read_latency", lat, 3);
    check("read_busy_cycles", bcnt, 3);
    check("read_data", {16'd0, bus.mem_rdata}, 32'hBEEF);

    do_op(1'b0, 1'b1, 2'b11, 16'h0040, 16'h1234, lat, bcnt, err);
    check("write_latency", lat, 3);
    check("rdata_held_over_write", {16'd0, bus.mem_rdata}, 32'hBEEF);
    do_op(1'b0, 1'b1, 2'b10, 16'h0040, 16'hAB00, lat, bcnt, err);
    do_op(1'b0, 1'b1, 2'b01, 16'h0040, 16'h00CD, lat, bcnt, err);
    do_op(1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, lat, bcnt, err);
    check("byte_merge", {16'd0, bus.mem_rdata}, 32'hABCD);

    do_op(1'b0, 1'b1, 2'b00, 16'h0040, 16'h0000, lat, bcnt, err);
    check("be00_resp_latency", lat, 3);
    do_op(1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, lat, bcnt, err);
    check("be00_unchanged", {16'd0, bus.mem_rdata}, 32'hABCD);

    do_op(1'b1, 1'b1, 2'b11, 16'h0060, 16'h5555, lat, bcnt, err);
    check("rw_latency", lat, 3);
    check("rw_rdata_kept", {16'd0, bus.mem_rdata}, 32'hABCD);
    do_op(1'b1, 1'b0, 2'b00, 16'h0060, 16'h0000, lat, bcnt, err);
    check("rw_was_write", {16'd0, bus.mem_rdata}, 32'h5555);

    bus.mem_read    = 1'b1;
    bus.mem_address = 16'h0020;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.mem_resp) begin lat = n; break; end
    end
    check("b2b_first_latency", lat, 3);
    gap = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.mem_resp) begin gap = n; break; end
    end
    check("b2b_period", gap, 4);
    check("b2b_data", {16'd0, bus.mem_rdata}, 32'hBEEF);
    bus.mem_read = 1'b0;
    @(negedge clk);

    bus.mem_write       = 1'b1;
    bus.mem_byte_enable = 2'b11;
    bus.mem_address     = 16'h0080;
    bus.mem_wdata       = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    check("midop_busy_wait1", {31'd0, bus.busy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midop_rst_resp", {31'd0, bus.mem_resp}, 32'd0);
    check("midop_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("midop_rst_rdata", {16'd0, bus.mem_rdata}, 32'h0000);
    bus.mem_write = 1'b0;
    @(negedge clk);
    check("midop_no_resp", {31'd0, bus.mem_resp}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(1'b1, 1'b0, 2'b00, 16'h0080, 16'h0000, lat, bcnt, err);
    check("midop_not_committed", {16'd0, bus.mem_rdata}, 32'h0001);

    do_op(1'b0, 1'b1, 2'b11, 16'h0802, 16'h7777, lat, bcnt, err);
    check("wrap_write_latency", lat, 3);
`ifdef LC3B_MEM_BOUNDS_CHECK_EN
    check("oob_write_err", {31'd0, err}, 32'd1);
    do_op(1'b1, 1'b0, 2'b00, 16'h0002, 16'h0000, lat, bcnt, err);
    check("oob_word1_unchanged", {16'd0, bus.mem_rdata}, 32'h1111);
    check("inrange_no_err", {31'd0, err}, 32'd0);
    do_op(1'b1, 1'b0, 2'b00, 16'h0802, 16'h0000, lat, bcnt, err);
    check("oob_read_zero", {16'd0, bus.mem_rdata}, 32'h0000);
    check("oob_read_err", {31'd0, err}, 32'd1);
`else
    do_op(1'b1, 1'b0, 2'b00, 16'h0002, 16'h0000, lat, bcnt, err);
    check("wrap_read", {16'd0, bus.mem_rdata}, 32'h7777);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3b_data_mem_responder.md
Name: lc3b_data_mem_responder

Overview:
- Memory-side responder for the pipeline's MEM-stage data port.
- Accepts the read/write requests the MEM stage issues and returns read data with a registered `mem_resp` handshake after a fixed, parameterised latency.
- Backs a word-organised, byte-writable array.
- Used as the data memory in simulation and as the template for the cache/arbiter-facing port.

Parameters:
- ADDR_WIDTH, 16, width of the byte address.
- DEPTH_WORDS, 1024, number of 16-bit words in the backing array (power of two).
- LATENCY, 3, cycles from the request-accept edge to the `mem_resp` cycle. Legal range 1..15; a value of 0 is a synthesis-time error.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- mem_read  in  1  read request; held high by the requester until `mem_resp`.
- mem_write  in  1  write request; held high by the requester until `mem_resp`.
- mem_byte_enable  in  2  bit0 = low byte, bit1 = high byte; writes only.
- mem_address  in  ADDR_WIDTH  byte address; bit 0 is ignored (word access).
- mem_wdata  in  16  write data.
- mem_resp  out  1  one-cycle completion pulse.
- mem_rdata  out  16  read data; valid in the `mem_resp` cycle, held until the next read completes.
- busy  out  1  high while a request is in flight (states WAIT and RESP).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; mem_resp=0, mem_rdata=16'h0000, busy=0; latency counter=0.
  - Array contents are not reset.
  - Reset during WAIT aborts the request; a pending write is never committed.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On the first edge with mem_read|mem_write=1, latch op, word index, wdata and byte enables; load counter=LATENCY-1.
  - Next state is WAIT, or RESP directly if LATENCY=1.
  - If both mem_read and mem_write are high, the write wins; the read is ignored (no data returned).
- WAIT: decrement the counter each cycle; when counter==0, the next state is RESP. Request inputs are ignored (not re-sampled) while busy.
- Commit and response timing:
  - The array access is performed at the edge entering RESP.
  - Writes update the enabled bytes; mem_rdata is registered for reads.
  - mem_resp=1 for exactly the single RESP cycle.
  - The first response comes LATENCY cycles after the accept edge.
- RESP: unconditionally return to IDLE. Request inputs in the RESP cycle are not accepted; the requester drops or re-issues them, and they are sampled in IDLE on the following cycle. Minimum back-to-back period is LATENCY+1 cycles.
- Addressing: word index = mem_address[ADDR_WIDTH-1:1] modulo DEPTH_WORDS (wrap-around).
- Byte enables:
  - byte_enable=2'b00 on a write still completes with mem_resp and leaves the array unchanged.
  - Reads always return the full word regardless of enables.
- mem_rdata is unchanged by writes and by reset-free idle cycles.

Optional Feature:
- Macro: LC3B_MEM_BOUNDS_CHECK_EN.
- Defined:
  - Adds output `mem_err` (1 bit, reset 0), which pulses in the RESP cycle when the unwrapped word index ≥ DEPTH_WORDS.
  - An erroring write is suppressed; an erroring read returns 16'h0000.
  - There is no wrap-around in this mode.
- Undefined: the `mem_err` port is absent and addresses wrap modulo DEPTH_WORDS.

Decomposition:
- Shared package lc3b_types:
  - lc3b_word (16-bit) and lc3b_mem_wmask (2-bit) typedefs.
  - enum lc3b_mem_state {IDLE, WAIT, RESP}.
  - constant LC3B_MEM_MAX_LATENCY=15.
- One sub-module: lc3b_mem_array, a synchronous single-port word array with a 2-bit byte-write mask, one read or write per cycle, and no reset.
- The responder owns the FSM, counter, request latches and output registers.

Test Plan:
- Reset/read: rst_n low for 2 cycles, preload word[0x10]=16'hBEEF via a hierarchical write, then read addr 16'h0020 with LATENCY=3 → mem_resp high exactly 3 cycles after the accept edge for 1 cycle, mem_rdata=16'hBEEF, busy high for 3 cycles.
- Byte writes:
  - Write 16'h1234 with BE=11 to 0x0040.
  - Write 16'hAB00 with BE=10.
  - Write 16'h00CD with BE=01.
  - Read back → 16'hABCD.
  - A write with BE=00 → mem_resp pulses and the word stays 16'hABCD.
- Simultaneous read and write to 0x0060 with wdata 16'h5555 → treated as a write; mem_rdata keeps its prior value; a subsequent read returns 16'h5555.
- Back-to-back: hold mem_read through RESP and into the next cycle → second accept occurs in IDLE after RESP; two mem_resp pulses are LATENCY+1 cycles apart.
- Reset mid-op: issue a write of 16'hFFFF to 0x0080 (old value 16'h0001), assert rst_n low in the 2nd WAIT cycle → no mem_resp, outputs at reset values; a subsequent read returns 16'h0001.
- Wrap/bounds with DEPTH_WORDS=1024:
  - Write 16'h7777 to byte address 16'h0802.
  - Macro undefined: reading 16'h0002 returns 16'h7777.
  - Macro defined: the write raises mem_err with mem_resp, and word 1 is unchanged.
